concatenador_nonce: RTL

Parametrised successor to the fixed 96+32-bit header/nonce concatenator. Latches a header word, sweeps a nonce range by itself, and emits `{header, nonce}` blocks to the downstream hash core over a valid/ready handshake, one block per cycle. The sweep stops on a hash hit or when the range is exhausted. Sits between the job loader and the hash pipeline.

---
 rtl/concatenador_pkg.sv | 29 ++
 rtl/nonce_counter.sv | 38 +++
 rtl/concatenador_nonce.sv | 116 +++++++++++
 3 files changed

// File: rtl/concatenador_pkg.sv
// Shared types and helpers for the header/nonce concatenator.
// Holds the FSM state encoding, the block width derivation and the nonce byte-swap helper.
package concatenador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The swap helper works on a wide container so that a single function
  // serves every NONCE_W. Callers cast their value into and out of it.
  localparam int NONCE_MAX_W = 256;

  function automatic int block_w(input int header_w, input int nonce_w);
    return header_w + nonce_w;
  endfunction

  function automatic logic [NONCE_MAX_W-1:0] byte_swap(input logic [NONCE_MAX_W-1:0] v,
                                                       input int nbytes);
    logic [NONCE_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < NONCE_MAX_W / 8; i++) begin
      if (i < nbytes) r[(nbytes - 1 - i) * 8 +: 8] = v[i * 8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/nonce_counter.sv
// Nonce register for one sweep: loads the first nonce and the limit, then advances by STEP.
// last_o flags that the nonce currently presented is the final one permitted in the range.
module nonce_counter #(
  parameter int                 NONCE_W = 32,
  parameter logic [NONCE_W-1:0] STEP    = {{(NONCE_W-1){1'b0}}, 1'b1}
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               load_i,
  input  logic               adv_i,
  input  logic [NONCE_W-1:0] start_i,
  input  logic [NONCE_W-1:0] limit_i,
  output logic [NONCE_W-1:0] nonce_o,
  output logic               last_o
);

  logic [NONCE_W-1:0] nonce_q;
  logic [NONCE_W-1:0] limit_q;
  logic [NONCE_W-1:0] remain;

  // Distance to the limit, taken modulo 2^NONCE_W, so a range that wraps through 0 behaves correctly.
  assign remain  = limit_q - nonce_q;
  assign last_o  = remain < STEP;
  assign nonce_o = nonce_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      nonce_q <= '0;
      limit_q <= '0;
    end else if (load_i) begin
      nonce_q <= start_i;
      limit_q <= limit_i;
    end else if (adv_i) begin
      nonce_q <= nonce_q + STEP;
    end
  end

endmodule

// File: rtl/concatenador_nonce.sv
// Header/nonce concatenator: sweeps a nonce range and emits {header, nonce} blocks over valid/ready.
// Define CONCAT_BYTE_SWAP_EN to byte-reverse the nonce field inside bloque_in.
module concatenador_nonce
  import concatenador_pkg::*;
#(
  parameter int              HEADER_W   = 96,
  parameter int              NONCE_W    = 32,
  parameter longint unsigned NONCE_STEP = 1
) (
  input  logic                        clk,
  input  logic                        reset_L,
  input  logic                        start,
  input  logic [HEADER_W-1:0]         entrada,
  input  logic [NONCE_W-1:0]          nonce_start,
  input  logic [NONCE_W-1:0]          nonce_limit,
  input  logic                        hit,
  input  logic                        bloque_ready,
  output logic                        bloque_valid,
  output logic [HEADER_W+NONCE_W-1:0] bloque_in,
  output logic [NONCE_W-1:0]          nonce,
  output logic                        busy,
  output logic                        done,
  output logic                        found,
  output logic                        exhausted,
  output state_e                      state_dbg
);

  localparam int BLOCK_W = block_w(HEADER_W, NONCE_W);

  // Handshake: a block transfers on every rising edge where bloque_valid and
  // bloque_ready are both high; while valid is high and ready is low the block
  // stays unchanged, and valid never drops before the transfer (except on hit).
  state_e              state_q;
  logic [HEADER_W-1:0] header_q;
  logic                valid_q, busy_q, done_q, found_q, exh_q;
  logic                handshake, last, load, adv;
  logic [NONCE_W-1:0]  nonce_q;
  logic [NONCE_W-1:0]  nonce_field;
  logic [BLOCK_W-1:0]  block;

  assign handshake = valid_q && bloque_ready;
  assign load      = (state_q == ST_IDLE) && start;
  assign adv       = (state_q == ST_RUN) && handshake && !hit && !last;

  nonce_counter #(
    .NONCE_W (NONCE_W),
    .STEP    (NONCE_W'(NONCE_STEP))
  ) u_counter (
    .clk     (clk),
    .reset_L (reset_L),
    .load_i  (load),
    .adv_i   (adv),
    .start_i (nonce_start),
    .limit_i (nonce_limit),
    .nonce_o (nonce_q),
    .last_o  (last)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= ST_IDLE;
      header_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      exh_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            header_q <= entrada;
            found_q  <= 1'b0;
            exh_q    <= 1'b0;
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          // hit wins over the range check, even when both land on the same edge.
          if (hit || (handshake && last)) begin
            found_q <= hit;
            exh_q   <= !hit;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef CONCAT_BYTE_SWAP_EN
  assign nonce_field = NONCE_W'(byte_swap(NONCE_MAX_W'(nonce_q), NONCE_W / 8));
`else
  assign nonce_field = nonce_q;
`endif

  assign block        = {header_q, nonce_field};
  assign bloque_in    = block;
  assign nonce        = nonce_q;
  assign bloque_valid = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign found        = found_q;
  assign exhausted    = exh_q;
  assign state_dbg    = state_q;

endmodule
